// File: rtl/button_event_ctrl.sv
// Avalon-MM push-button controller: two-flop synchroniser, per-bit debounce,
// sticky edge capture with write-1-to-clear and a maskable level interrupt.
module button_event_ctrl #(
  parameter int WIDTH            = 4,
  parameter int CNT_W            = 20,
  parameter int DEBOUNCE_DEFAULT = 50000,
  parameter int IDLE_LEVEL       = 1,
  parameter int EDGE_TYPE        = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic             IDLE_B     = (IDLE_LEVEL != 0);
  localparam logic [WIDTH-1:0] IDLE_V     = {WIDTH{IDLE_B}};
  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(DEBOUNCE_DEFAULT);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_deb;
  logic [WIDTH-1:0] r_deb_prev;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [CNT_W-1:0] r_period;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;

  logic             w_wr;
  logic [CNT_W-1:0] w_eff_period;
  logic [WIDTH-1:0] w_ev;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd;
  logic             w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_eff_period   = (r_period == '0) ? ONE_C : r_period;
  assign w_clr          = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign irq            = |(r_cap & r_mask);
  assign w_unused_wdata = ^writedata;

  always_comb begin
    case (EDGE_TYPE)
      0:       w_ev = r_deb & ~r_deb_prev;
      1:       w_ev = ~r_deb & r_deb_prev;
      default: w_ev = r_deb ^ r_deb_prev;
    endcase
  end

  always_comb begin
    w_rd = '0;
    case (address)
      2'd0: w_rd[WIDTH-1:0] = r_deb;
      2'd1: w_rd[CNT_W-1:0] = r_period;
      2'd2: w_rd[WIDTH-1:0] = r_mask;
      2'd3: w_rd[WIDTH-1:0] = r_cap;
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= IDLE_V;
      r_sync2    <= IDLE_V;
      r_deb      <= IDLE_V;
      r_deb_prev <= IDLE_V;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      r_period   <= PERIOD_RST;
      r_mask     <= '0;
      r_cap      <= '0;
      readdata   <= '0;
    end else begin
      r_sync1    <= in_port;
      r_sync2    <= r_sync1;
      r_deb_prev <= r_deb;
      // The >= test lets a lowered period finish a long-running count at once.
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (({1'b0, r_cnt[i]} + {1'b0, ONE_C}) >= {1'b0, w_eff_period}) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + ONE_C;
        end
      end
      // A new event on the same bit as a clear wins over the clear.
      r_cap <= (r_cap & ~w_clr) | w_ev;
      if (w_wr && address == 2'd1) r_period <= writedata[CNT_W-1:0];
      if (w_wr && address == 2'd2) r_mask   <= writedata[WIDTH-1:0];
      readdata <= w_rd;
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: a falling-edge instance and an
// any-change instance share the bus and pins.
module tb_button_event_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] readdata_any;
  logic [3:0]  in_port;
  logic        irq;
  logic        irq_any;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_event_ctrl #(.WIDTH(4), .CNT_W(20), .DEBOUNCE_DEFAULT(50000),
                      .IDLE_LEVEL(1), .EDGE_TYPE(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  button_event_ctrl #(.WIDTH(4), .CNT_W(20), .DEBOUNCE_DEFAULT(50000),
                      .IDLE_LEVEL(1), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_any),
    .in_port(in_port), .irq(irq_any)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    address = a;
    tick(1);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;

    // Reset state
    tick(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    bus_rd(2'd0); check("rst_deb", readdata, 32'hF);
    bus_rd(2'd1); check("rst_period", readdata, 32'd50000);
    bus_rd(2'd2); check("rst_mask", readdata, 32'h0);
    bus_rd(2'd3); check("rst_cap", readdata, 32'h0);

    // Clean press on bit0, period 4: deb changes on the 6th edge after the pin
    bus_wr(2'd1, 32'd4);
    bus_wr(2'd2, 32'h1);
    bus_rd(2'd1); check("period_rb", readdata, 32'd4);
    address = 2'd0;
    in_port[0] = 1'b0;
    tick(6);
    check("press_deb_before", readdata, 32'hF);
    check("press_irq_before", {31'b0, irq}, 32'h0);
    tick(1);
    check("press_deb_after", readdata, 32'hE);
    check("press_irq_after", {31'b0, irq}, 32'h1);
    bus_rd(2'd3); check("press_cap", readdata, 32'h1);

    // Release (no capture on a falling-only instance), clear, then bounce bit1
    in_port[0] = 1'b1;
    tick(10);
    bus_wr(2'd3, 32'h1);
    check("clr_irq", {31'b0, irq}, 32'h0);
    bus_rd(2'd3); check("clr_cap", readdata, 32'h0);
    in_port[1] = 1'b0; tick(3);
    in_port[1] = 1'b1; tick(2);
    in_port[1] = 1'b0; tick(3);
    in_port[1] = 1'b1; tick(12);
    bus_rd(2'd0); check("bounce_deb", readdata, 32'hF);
    bus_rd(2'd3); check("bounce_cap", readdata, 32'h0);
    check("bounce_irq", {31'b0, irq}, 32'h0);

    // Clear racing a fresh capture on bit0
    in_port[0] = 1'b0;
    tick(8);
    check("race_pending_irq", {31'b0, irq}, 32'h1);
    in_port[0] = 1'b1;
    tick(10);
    in_port[0] = 1'b0;
    tick(6);
    bus_wr(2'd3, 32'h1);
    check("race_irq", {31'b0, irq}, 32'h1);
    bus_rd(2'd3); check("race_cap", readdata, 32'h1);
    bus_wr(2'd3, 32'h1);
    check("race_clr_irq", {31'b0, irq}, 32'h0);
    bus_rd(2'd3); check("race_clr_cap", readdata, 32'h0);
    in_port[0] = 1'b1;
    tick(10);

    // Mask gating with any-change capture on bit2
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    bus_wr(2'd1, 32'd4);
    in_port[2] = 1'b0;
    tick(10);
    bus_rd(2'd3);
    check("any_press_cap", readdata_any, 32'h4);
    check("fall_press_cap", readdata, 32'h4);
    bus_wr(2'd3, 32'h4);
    in_port[2] = 1'b1;
    tick(10);
    bus_rd(2'd3);
    check("any_release_cap", readdata_any, 32'h4);
    check("fall_release_cap", readdata, 32'h0);
    check("any_masked_irq", {31'b0, irq_any}, 32'h0);
    bus_wr(2'd2, 32'h4);
    check("any_unmask_irq", {31'b0, irq_any}, 32'h1);
    check("fall_unmask_irq", {31'b0, irq}, 32'h0);
    bus_wr(2'd2, 32'h0);
    check("any_remask_irq", {31'b0, irq_any}, 32'h0);

    // Period shrink under a running count on bit3
    bus_wr(2'd1, 32'd100);
    in_port[3] = 1'b0;
    tick(50);
    bus_wr(2'd1, 32'd10);
    bus_rd(2'd0); check("shrink_deb_before", readdata, 32'hF);
    bus_rd(2'd0); check("shrink_deb_after", readdata, 32'h7);
    in_port[3] = 1'b1;
    tick(20);
    bus_wr(2'd3, 32'hF);

    // Reset in the middle of a debounce count
    bus_wr(2'd1, 32'd100);
    in_port[3] = 1'b0;
    tick(30);
    reset_n = 1'b0;
    tick(2);
    check("midrst_readdata", readdata, 32'h0);
    check("midrst_cnt", 32'(dut.r_cnt[3]), 32'h0);
    reset_n = 1'b1;
    bus_rd(2'd0); check("midrst_deb", readdata, 32'hF);
    bus_rd(2'd3); check("midrst_cap", readdata, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    in_port[3] = 1'b1;
    tick(5);
    bus_rd(2'd0); check("midrst_deb_idle", readdata, 32'hF);
    bus_rd(2'd1); check("midrst_period", readdata, 32'd50000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
